fir_lut_loader: RTL

- Sequencer that configures the distributed-arithmetic FIR filter.
- Holds 64 signed 16-bit tap coefficients written by a host.
- On start, generates all 2048 LUT partial sums (8 groups × 256 entries) and drives them onto the filter's CIN/CADDR/CLOAD load port.
- After the last word it asserts the filter's valid_in enable. It sits between the host/config bus and fir_filter.

---
 rtl/fir_lut_loader_pkg.sv | 18 +
 rtl/fir_lut_loader_if.sv | 27 ++
 rtl/fir_lut_gray_acc.sv | 50 +++++
 rtl/fir_lut_loader.sv | 115 +++++++++++
 4 files changed

// File: rtl/fir_lut_loader_pkg.sv
// Shared constants, FSM state type and Gray helper for the DA-FIR LUT loader.
package fir_pkg;

  localparam int unsigned NTAP      = 64;
  localparam int unsigned CW        = 16;
  localparam int unsigned LW        = 20;
  localparam int unsigned GROUP_SZ  = 8;
  localparam int unsigned NGROUP    = NTAP / GROUP_SZ;
  localparam int unsigned LUT_DEPTH = 2048;
  localparam int unsigned ENTRIES   = LUT_DEPTH / NGROUP;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  function automatic logic [7:0] gray8(input logic [7:0] n);
    return n ^ (n >> 1);
  endfunction

endpackage

// File: rtl/fir_lut_loader_if.sv
// Host/config bus plus filter load port of the LUT loader.
interface fir_lut_loader_if;
  import fir_pkg::*;

  logic                 coef_we;
  logic [5:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 start;
  logic signed [LW-1:0] CIN;
  logic [10:0]          CADDR;
  logic                 CLOAD;
  logic                 filt_valid_in;
  logic                 busy;
  logic                 done;
  logic                 wr_err;

  modport master (
    output coef_we, coef_addr, coef_data, start,
    input  CIN, CADDR, CLOAD, filt_valid_in, busy, done, wr_err
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, start,
    output CIN, CADDR, CLOAD, filt_valid_in, busy, done, wr_err
  );

endinterface

// File: rtl/fir_lut_gray_acc.sv
// Per-group Gray-order entry counter with add/subtract running partial sum.
module fir_lut_gray_acc
  import fir_pkg::*;
(
  input  logic                 clk_fast,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 step,
  input  logic signed [CW-1:0] coef,
  output logic signed [LW-1:0] sum,
  output logic [7:0]           gray,
  output logic [2:0]           sel,
  output logic                 at_end
);

  logic [7:0]           n;
  logic [7:0]           n_nx;
  logic [7:0]           g_nx;
  logic                 up;
  logic signed [LW-1:0] ext;

  // sel is the single Gray bit that flips on n -> n+1 (trailing zeros of n+1)
  always_comb begin
    n_nx = n + 8'd1;
    g_nx = gray8(n_nx);
    sel  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (n_nx[7-i]) sel = 3'(7 - i);
    end
    up  = g_nx[sel];
    ext = {{(LW-CW){coef[CW-1]}}, coef};
  end

  assign gray   = gray8(n);
  assign at_end = (n == 8'(ENTRIES - 1));

  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      n   <= '0;
      sum <= '0;
    end else if (clear) begin
      n   <= '0;
      sum <= '0;
    end else if (step) begin
      n   <= n_nx;
      sum <= up ? sum + ext : sum - ext;
    end
  end

endmodule

// File: rtl/fir_lut_loader.sv
// Coefficient store, LOAD/RUN sequencer and word pacing that streams the
// 8x256 DA partial-sum LUT into fir_filter, then enables it.
module fir_lut_loader
  import fir_pkg::*;
#(
  parameter int unsigned WR_DIV = 1
) (
  input  logic             clk_fast,
  input  logic             reset,
  fir_lut_loader_if.slave  bus
);

  state_t               state;
  logic signed [CW-1:0] coef [NGROUP][GROUP_SZ];
  logic [2:0]           g;
  logic [7:0]           div;
  logic                 cload_r, valid_r, busy_r, done_r, wr_err_r;
  logic                 acc_clear, acc_step, at_end, div_wrap, last_word;
  logic [2:0]           sel;
  logic [7:0]           gray;
  logic signed [LW-1:0] sum;

  assign div_wrap  = (div == 8'(WR_DIV - 1));
  assign last_word = at_end && (g == 3'(NGROUP - 1));

  always_comb begin
    acc_clear = 1'b0;
    acc_step  = 1'b0;
    if (state == LOAD) begin
      if (div_wrap) begin
        if (at_end) acc_clear = !last_word;
        else        acc_step  = 1'b1;
      end
    end else begin
      acc_clear = bus.start;
    end
  end

  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NGROUP; i++)
        for (int unsigned j = 0; j < GROUP_SZ; j++)
          coef[i][j] <= '0;
    end else if (bus.coef_we && state != LOAD) begin
      coef[bus.coef_addr[5:3]][bus.coef_addr[2:0]] <= bus.coef_data;
    end
  end

  fir_lut_gray_acc u_acc (
    .clk_fast (clk_fast),
    .reset    (reset),
    .clear    (acc_clear),
    .step     (acc_step),
    .coef     (coef[g][sel]),
    .sum      (sum),
    .gray     (gray),
    .sel      (sel),
    .at_end   (at_end)
  );

  always_ff @(posedge clk_fast or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      g        <= '0;
      div      <= '0;
      cload_r  <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      wr_err_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      wr_err_r <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.start) begin
            state   <= LOAD;
            g       <= '0;
            div     <= '0;
            cload_r <= 1'b1;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        LOAD: begin
          wr_err_r <= bus.coef_we;
          if (div_wrap) begin
            div <= '0;
            if (last_word) begin
              state   <= RUN;
              cload_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              valid_r <= 1'b1;
            end else if (at_end) begin
              g <= g + 3'd1;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.CIN           = sum;
  assign bus.CADDR         = {g, gray};
  assign bus.CLOAD         = cload_r;
  assign bus.filt_valid_in = valid_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.wr_err        = wr_err_r;

endmodule
